// File: rtl/sync_edge_filter.sv
// Debounces a synchronized level and reports each accepted edge as a pulse
// and as an event in a one-entry valid/ready holding register.
module sync_edge_filter #(
  parameter logic        INIT     = 1'b0,
  parameter int unsigned FILTER_W = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_in,
  input  logic [FILTER_W-1:0] cfg_filt_len,
  output logic                f_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic                evt_edge,
  output logic [CNT_W-1:0]    evt_seq,
  output logic                evt_ovf,
  input  logic                evt_ovf_clr
);

  logic [FILTER_W-1:0] cnt_q, cnt_d;
  logic                f_q, f_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic                evt_valid_q, evt_valid_d;
  logic                evt_edge_q, evt_edge_d;
  logic [CNT_W-1:0]    evt_seq_q, evt_seq_d;
  logic                evt_ovf_q, evt_ovf_d;
  logic                mismatch;
  logic                accept;
  logic                drop;

  always_comb begin
    mismatch    = (s_in != f_q);
    accept      = mismatch && (cnt_q >= cfg_filt_len);
    drop        = 1'b0;
    cnt_d       = cnt_q;
    f_d         = f_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    edge_cnt_d  = edge_cnt_q;
    evt_valid_d = evt_valid_q;
    evt_edge_d  = evt_edge_q;
    evt_seq_d   = evt_seq_q;
    evt_ovf_d   = evt_ovf_q;

    // cnt only grows while below cfg_filt_len, so it cannot wrap
    if (!mismatch || accept) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + FILTER_W'(1);
    end

    if (accept) begin
      f_d        = s_in;
      rise_d     = s_in;
      fall_d     = ~s_in;
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_edge_d  = s_in;
        evt_seq_d   = edge_cnt_d;
      end else begin
        drop = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    // A drop in the same cycle as a clear keeps the flag set
    if (drop) begin
      evt_ovf_d = 1'b1;
    end else if (evt_ovf_clr) begin
      evt_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      f_q         <= INIT;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      edge_cnt_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_edge_q  <= 1'b0;
      evt_seq_q   <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      f_q         <= f_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      edge_cnt_q  <= edge_cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_edge_q  <= evt_edge_d;
      evt_seq_q   <= evt_seq_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign f_out      = f_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign evt_valid  = evt_valid_q;
  assign evt_edge   = evt_edge_q;
  assign evt_seq    = evt_seq_q;
  assign evt_ovf    = evt_ovf_q;

endmodule
